qpi_psram_if: RTL and testbench
===============================

Name: qpi_psram_if

Overview:
- Single-word QPI controller for one APS6404-class PSRAM. Drives the nce/sclk/sout/oe pins and receives sin, all of which connect to the board-level tristate pads.
- On the SoC side, the memory arbiter issues one 32-bit read or write at a time.
- After reset, it switches the chip from SPI to QPI mode, then serves requests.
- Two instances exist, one for PSRAM A and one for PSRAM B.

Parameters:
- READ_WAIT, 6: wait cycles (sclk periods) between address and read data for command 0xEB.
- INIT_QPI, 1: when 1, send 0x35 (enter QPI) in SPI mode after reset. When 0, go straight to IDLE.

Ports:
- clk, in, 1: system clock, 48 MHz.
- rst, in, 1: asynchronous, active-high reset.
- addr, in, 24: byte address, latched on accept.
- wdata, in, 32: write word, latched on accept. wdata[31:28] is shifted out first.
- do_read, in, 1: read request, sampled when busy=0.
- do_write, in, 1: write request, sampled when busy=0.
- rdata, out, 32: read word. The first nibble received lands in [31:28]. Holds its value until the next read completes.
- valid, out, 1: one-clk pulse on read or write completion.
- busy, out, 1: high during init and while a transaction is in flight.
- psram_nce, out, 1: chip enable, active low.
- psram_sclk, out, 1: serial clock, clk/2 while active.
- psram_sout, out, 4: data to pins.
- psram_sin, in, 4: data from pins.
- psram_oe, out, 1: 1 = drive sout onto the pins.

Behaviour:
- Reset values (asynchronous, immediate, also mid-transaction): nce=1, sclk=0, sout=0, oe=0, valid=0, rdata=0, busy=1.
  - A reset mid-transaction aborts it with no valid pulse, then init re-runs.
- States: INIT, IDLE, CMD, ADDR, WAIT, DATA, GAP.
- Serial timing:
  - Each sclk period is 2 clk: low phase, then high phase.
  - sout, oe and nce change only on the clk edge that makes sclk low.
  - sin is sampled on the clk edge that ends a high phase.
  - sclk stays 0 whenever nce=1.
- INIT (INIT_QPI=1):
  - First clk after rst deasserts: nce=0, oe=1.
  - 8 sclk periods shift 0x35 MSB-first on sout[0]; sout[3:1]=0.
  - Then GAP, then IDLE.
  - Busy stays 1 throughout; requests are ignored.
- IDLE, accept rule:
  - Accept in cycle N if busy=0 and (do_read or do_write).
  - If both are high, the read wins and the write is dropped.
  - busy=1 from N+1. Requests while busy are ignored; there is no queue.
- Each QPI nibble occupies one sclk period, MSB nibble first.
  - CMD: 2 nibbles, 0xEB for read or 0x38 for write.
  - ADDR: 6 nibbles of addr[23:0].
  - WAIT (read only): READ_WAIT periods with oe=0.
  - DATA, write: 8 nibbles of wdata with oe=1.
  - DATA, read: 8 periods with oe=0; sin is shifted into rdata LSB-side, so after 8 shifts the first nibble sits at [31:28].
- oe is 1 in CMD and ADDR, and in DATA for writes. oe goes 0 starting at the first WAIT low phase.
- Cycle counts, with T nibble periods per transaction:
  - T=16 for a write; T=2+6+READ_WAIT+8 for a read (22 at the default).
  - nce=0 at N+1; first sclk rise at N+2; last sclk fall at N+2T+1.
  - At N+2T+1: nce=1, oe=0, valid=1 for 1 clk, and rdata updated at the same edge for reads.
  - GAP holds nce=1 for 2 clk. busy=0 at N+2T+3; a new request is accepted at the earliest in that cycle.
  - Write: nce low for 32 clk, valid at N+33, idle at N+35.
  - Read: valid at N+45, idle at N+47.
- Counters:
  - A 5-bit nibble counter and a phase bit.
  - No wrap within a transaction. Address increment across words is the arbiter's job; the chip's 1 KB page wrap does not apply to single-word bursts.

Test Plan:
- Reset release with INIT_QPI=1:
  - sout[0] carries 0,0,1,1,0,1,0,1 on 8 sclk rises with nce=0.
  - Then nce=1, and busy=0 exactly 1+16+2 clk after release.
- Write, addr=0x123456, wdata=0xDEADBEEF:
  - Nibbles on sclk rises: 3,8,1,2,3,4,5,6,D,E,A,D,B,E,E,F, with oe=1 throughout.
  - valid at N+33; busy=0 at N+35.
- Read, addr=0x000010, model drives 0xCAFEF00D after 6 wait periods:
  - Command nibbles E,B; oe=0 from wait start.
  - rdata=0xCAFEF00D with valid at N+45.
- do_read and do_write asserted together in IDLE:
  - Only command 0xEB is issued; one valid pulse only.
- do_write pulsed while busy mid-read:
  - Ignored; there is no second nce low period after the read.
- rst asserted during write ADDR phase:
  - Same clk: nce=1, sclk=0, oe=0, valid never pulses.
  - After release, init runs again, then a read returns correct data.

Source files
------------

// File: rtl/qpi_psram_if.sv
// -----------------------------------------------------------------------------
// qpi_psram_if
//
// Single-word QPI controller for one APS6404-class PSRAM. After reset it
// optionally sends the "enter QPI" command (0x35) in SPI mode, then serves one
// 32-bit read (0xEB) or write (0x38) request at a time from the SoC arbiter.
//
// Ports
//   clk          system clock (48 MHz); sclk runs at clk/2 while active
//   rst          asynchronous, active-high reset
//   addr         byte address, latched on accept
//   wdata        write word, latched on accept, [31:28] shifted out first
//   do_read      read request, sampled while busy=0 (wins over do_write)
//   do_write     write request, sampled while busy=0
//   rdata        read word, first received nibble in [31:28]; held until the
//                next read completes
//   valid        one-clk pulse when a read or write completes
//   busy         high during init and while a transaction is in flight
//   psram_nce    chip enable, active low
//   psram_sclk   serial clock
//   psram_sout   nibble to the pads
//   psram_sin    nibble from the pads
//   psram_oe     1 = drive psram_sout onto the pads
//
// Serial timing: every sclk period is two clk cycles (low phase, then high
// phase). sout/oe/nce only change on the edge that starts a low phase, and sin
// is sampled on the edge that ends a high phase.
// -----------------------------------------------------------------------------
module qpi_psram_if #(
    parameter int READ_WAIT = 6,
    parameter int INIT_QPI  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] addr,
    input  logic [31:0] wdata,
    input  logic        do_read,
    input  logic        do_write,
    output logic [31:0] rdata,
    output logic        valid,
    output logic        busy,
    output logic        psram_nce,
    output logic        psram_sclk,
    output logic [3:0]  psram_sout,
    input  logic [3:0]  psram_sin,
    output logic        psram_oe
);

    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_CMD  = 3'd2;
    localparam logic [2:0] ST_ADDR = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;
    localparam logic [2:0] ST_DATA = 3'd5;
    localparam logic [2:0] ST_GAP  = 3'd6;

    localparam logic [7:0] CMD_READ  = 8'hEB;
    localparam logic [7:0] CMD_WRITE = 8'h38;

    // 0x35 spread one bit per nibble so that in SPI mode the byte travels
    // MSB-first on sout[0] while sout[3:1] stay 0.
    localparam logic [63:0] INIT_FRAME = 64'h0011_0101_0000_0000;

    localparam logic [4:0] WAIT_LAST = (READ_WAIT > 0) ? 5'(READ_WAIT - 1) : 5'd0;

    // Registered state
    logic [2:0]  state_r;
    logic [4:0]  cnt_r;      // nibble index within the current state
    logic        phase_r;    // 0 = sclk low phase, 1 = sclk high phase
    logic        nce_r;
    logic        sclk_r;
    logic [3:0]  sout_r;
    logic        oe_r;
    logic        valid_r;
    logic        busy_r;
    logic [63:0] tx_r;       // nibbles still to send after the one on sout
    logic        rd_r;       // current transaction is a read
    logic [27:0] shift_r;    // first seven received nibbles of a read
    logic [31:0] rdata_r;

    // Next-state values
    logic [2:0]  state_s;
    logic [4:0]  cnt_s;
    logic        phase_s;
    logic        nce_s;
    logic        sclk_s;
    logic [3:0]  sout_s;
    logic        oe_s;
    logic        valid_s;
    logic        busy_s;
    logic [63:0] tx_s;
    logic        rd_s;
    logic [27:0] shift_s;
    logic [31:0] rdata_s;

    logic [63:0] req_frame_s;
    logic        active_s;
    logic        adv_s;
    logic        finish_s;

    // Complete serial frame for a newly accepted request (read wins a tie)
    always_comb begin
        if (do_read) begin
            req_frame_s = {CMD_READ, addr, 32'h0000_0000};
        end else begin
            req_frame_s = {CMD_WRITE, addr, wdata};
        end
    end

    // sclk is toggling in these states; adv_s marks the end of a high phase
    always_comb begin
        active_s = ((state_r == ST_INIT) && (INIT_QPI != 0) && !nce_r)
                 || (state_r == ST_CMD)  || (state_r == ST_ADDR)
                 || (state_r == ST_WAIT) || (state_r == ST_DATA);
        adv_s    = active_s && phase_r;
    end

    // Sequencer: serial clocking, nibble output, state transitions
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        phase_s  = phase_r;
        nce_s    = nce_r;
        sclk_s   = 1'b0;
        sout_s   = sout_r;
        oe_s     = oe_r;
        valid_s  = 1'b0;
        busy_s   = busy_r;
        tx_s     = tx_r;
        rd_s     = rd_r;
        shift_s  = shift_r;
        rdata_s  = rdata_r;
        finish_s = 1'b0;

        // Common clocking: a low phase turns into a high phase; the end of a
        // high phase presents the next nibble with sclk back low.
        if (active_s) begin
            if (phase_r == 1'b0) begin
                sclk_s  = 1'b1;
                phase_s = 1'b1;
            end else begin
                sclk_s  = 1'b0;
                phase_s = 1'b0;
                sout_s  = tx_r[63:60];
                tx_s    = {tx_r[59:0], 4'h0};
                cnt_s   = cnt_r + 5'd1;
            end
        end else begin
            phase_s = phase_r;
        end

        case (state_r)
            ST_INIT: begin
                if (INIT_QPI == 0) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else if (nce_r) begin
                    // Open the SPI-mode frame on the first clk after reset
                    nce_s   = 1'b0;
                    oe_s    = 1'b1;
                    phase_s = 1'b0;
                    cnt_s   = 5'd0;
                    sout_s  = INIT_FRAME[63:60];
                    tx_s    = {INIT_FRAME[59:0], 4'h0};
                end else if (adv_s && (cnt_r == 5'd7)) begin
                    finish_s = 1'b1;
                end else begin
                    finish_s = 1'b0;
                end
            end

            ST_IDLE: begin
                if (do_read || do_write) begin
                    state_s = ST_CMD;
                    busy_s  = 1'b1;
                    rd_s    = do_read;
                    nce_s   = 1'b0;
                    oe_s    = 1'b1;
                    phase_s = 1'b0;
                    cnt_s   = 5'd0;
                    sout_s  = req_frame_s[63:60];
                    tx_s    = {req_frame_s[59:0], 4'h0};
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_CMD: begin
                if (adv_s && (cnt_r == 5'd1)) begin
                    state_s = ST_ADDR;
                    cnt_s   = 5'd0;
                end else begin
                    state_s = ST_CMD;
                end
            end

            ST_ADDR: begin
                if (adv_s && (cnt_r == 5'd5)) begin
                    cnt_s = 5'd0;
                    if (!rd_r) begin
                        state_s = ST_DATA;
                    end else if (READ_WAIT > 0) begin
                        state_s = ST_WAIT;
                        oe_s    = 1'b0;
                    end else begin
                        state_s = ST_DATA;
                        oe_s    = 1'b0;
                    end
                end else begin
                    state_s = ST_ADDR;
                end
            end

            ST_WAIT: begin
                if (adv_s && (cnt_r == WAIT_LAST)) begin
                    state_s = ST_DATA;
                    cnt_s   = 5'd0;
                end else begin
                    state_s = ST_WAIT;
                end
            end

            ST_DATA: begin
                if (adv_s) begin
                    if (rd_r) begin
                        shift_s = {shift_r[23:0], psram_sin};
                    end else begin
                        shift_s = shift_r;
                    end
                    if (cnt_r == 5'd7) begin
                        finish_s = 1'b1;
                        valid_s  = 1'b1;
                        // The eighth nibble goes straight into rdata
                        if (rd_r) begin
                            rdata_s = {shift_r, psram_sin};
                        end else begin
                            rdata_s = rdata_r;
                        end
                    end else begin
                        finish_s = 1'b0;
                    end
                end else begin
                    shift_s = shift_r;
                end
            end

            ST_GAP: begin
                // nce stays high for two clk before the next request can start
                if (phase_r == 1'b0) begin
                    phase_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    phase_s = 1'b0;
                end
            end

            default: begin
                // Unreachable encoding: release the bus and resynchronise
                state_s = ST_GAP;
                nce_s   = 1'b1;
                oe_s    = 1'b0;
                sout_s  = 4'h0;
                phase_s = 1'b0;
                busy_s  = 1'b1;
            end
        endcase

        // End of a frame: deselect the chip and release the pads together
        if (finish_s) begin
            state_s = ST_GAP;
            nce_s   = 1'b1;
            oe_s    = 1'b0;
            sout_s  = 4'h0;
            sclk_s  = 1'b0;
            cnt_s   = 5'd0;
            phase_s = 1'b0;
        end else begin
            state_s = state_s;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_INIT;
            cnt_r   <= 5'd0;
            phase_r <= 1'b0;
            nce_r   <= 1'b1;
            sclk_r  <= 1'b0;
            sout_r  <= 4'h0;
            oe_r    <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b1;
            tx_r    <= 64'h0;
            rd_r    <= 1'b0;
            shift_r <= 28'h0;
            rdata_r <= 32'h0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            phase_r <= phase_s;
            nce_r   <= nce_s;
            sclk_r  <= sclk_s;
            sout_r  <= sout_s;
            oe_r    <= oe_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            tx_r    <= tx_s;
            rd_r    <= rd_s;
            shift_r <= shift_s;
            rdata_r <= rdata_s;
        end
    end

    assign rdata      = rdata_r;
    assign valid      = valid_r;
    assign busy       = busy_r;
    assign psram_nce  = nce_r;
    assign psram_sclk = sclk_r;
    assign psram_sout = sout_r;
    assign psram_oe   = oe_r;

endmodule

// File: tb/tb_qpi_psram_if.sv
// -----------------------------------------------------------------------------
// tb_qpi_psram_if
//
// Self-checking bench for qpi_psram_if. A behavioural PSRAM watches the pins,
// records every nibble on sclk high phases, stores completed writes into an
// associative memory and returns read data after the wait periods. Expected
// values come from the command/address/data rules and a reference memory.
// -----------------------------------------------------------------------------
module tb_qpi_psram_if;

    localparam int RW = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] addr = 24'h0;
    logic [31:0] wdata = 32'h0;
    logic        do_read = 1'b0;
    logic        do_write = 1'b0;
    logic [31:0] rdata;
    logic        valid;
    logic        busy;
    logic        psram_nce;
    logic        psram_sclk;
    logic [3:0]  psram_sout;
    logic [3:0]  psram_sin = 4'h0;
    logic        psram_oe;

    int tests = 0;
    int fails = 0;

    // Pin monitor / PSRAM model state
    logic [3:0] mon_nib [64];
    logic       mon_oe  [64];
    int         mon_cnt = 0;
    logic [3:0] last_nib [64];
    logic       last_oe  [64];
    int         last_len = 0;
    int         frames = 0;
    int         valid_cnt = 0;
    int         proto_err = 0;
    bit [31:0]  psram_mem [bit [23:0]];
    bit [31:0]  exp_mem   [bit [23:0]];

    qpi_psram_if #(.READ_WAIT(RW), .INIT_QPI(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .do_read    (do_read),
        .do_write   (do_write),
        .rdata      (rdata),
        .valid      (valid),
        .busy       (busy),
        .psram_nce  (psram_nce),
        .psram_sclk (psram_sclk),
        .psram_sout (psram_sout),
        .psram_sin  (psram_sin),
        .psram_oe   (psram_oe)
    );

    always #5 clk = ~clk;

    // Contents of never-written PSRAM locations
    function automatic bit [31:0] default_word(input bit [23:0] a);
        return {a[7:0], 8'h5A, a[23:8]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit [31:0] exp_read(input bit [23:0] a);
        if (exp_mem.exists(a)) return exp_mem[a];
        return default_word(a);
    endfunction

    // PSRAM model: sample pins mid high phase, drive read data, commit writes
    always @(negedge clk) begin
        int        d;
        bit [23:0] fa;
        bit [31:0] w;
        if (psram_nce && psram_sclk) proto_err++;
        if (valid) valid_cnt++;
        if (!psram_nce) begin
            if (psram_sclk && mon_cnt < 64) begin
                mon_nib[mon_cnt] = psram_sout;
                mon_oe[mon_cnt]  = psram_oe;
                if (mon_cnt >= 8 && {mon_nib[0], mon_nib[1]} == 8'hEB) begin
                    d  = mon_cnt - 8 - RW;
                    fa = {mon_nib[2], mon_nib[3], mon_nib[4], mon_nib[5], mon_nib[6], mon_nib[7]};
                    w  = psram_mem.exists(fa) ? psram_mem[fa] : default_word(fa);
                    if (d >= 0 && d < 8) psram_sin = w[(31 - 4*d) -: 4];
                    else psram_sin = 4'($urandom_range(0, 15));
                end
                mon_cnt++;
            end
        end else if (mon_cnt != 0) begin
            frames++;
            last_len = mon_cnt;
            for (int i = 0; i < 64; i++) begin
                last_nib[i] = mon_nib[i];
                last_oe[i]  = mon_oe[i];
            end
            if (mon_cnt == 16 && {mon_nib[0], mon_nib[1]} == 8'h38) begin
                fa = {mon_nib[2], mon_nib[3], mon_nib[4], mon_nib[5], mon_nib[6], mon_nib[7]};
                psram_mem[fa] = {mon_nib[8], mon_nib[9], mon_nib[10], mon_nib[11],
                                 mon_nib[12], mon_nib[13], mon_nib[14], mon_nib[15]};
            end
            mon_cnt = 0;
        end
    end

    // Issue one request at the first idle cycle and follow it to busy=0.
    // Cycle k counts clk edges after the accept edge (k=1 is cycle N+1).
    task automatic do_xfer(input logic rd, input logic wr, input logic [23:0] a,
                           input logic [31:0] d, output int vcyc, output int idle_cyc,
                           output logic [31:0] rv, output logic nce1, output logic busy1);
        int k;
        int guard;
        vcyc = 0; idle_cyc = 0; rv = 32'h0; nce1 = 1'b1; busy1 = 1'b0; guard = 0;
        while (busy && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        addr = a; wdata = d; do_read = rd; do_write = wr;
        @(posedge clk); #1;
        do_read = 1'b0; do_write = 1'b0;
        k = 1; nce1 = psram_nce; busy1 = busy;
        while (k < 200) begin
            if (valid && vcyc == 0) begin vcyc = k; rv = rdata; end
            if (!busy) begin idle_cyc = k; break; end
            @(posedge clk); #1; k++;
        end
    endtask

    task automatic test_reset();
        int k; int f0; int v0; int bad; logic n1, o1; logic [7:0] b;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (psram_nce !== 1'b1 || psram_sclk !== 1'b0 || psram_sout !== 4'h0 || psram_oe !== 1'b0
            || valid !== 1'b0 || rdata !== 32'h0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_values: nce=%b sclk=%b sout=%h oe=%b valid=%b rdata=%h busy=%b, need 1 0 0 0 0 00000000 1",
                     psram_nce, psram_sclk, psram_sout, psram_oe, valid, rdata, busy);
        end
        f0 = frames; v0 = valid_cnt;
        do_write = 1'b1;  // must be ignored during init
        rst = 1'b0;
        k = 0; n1 = 1'b1; o1 = 1'b0;
        while (k < 100) begin
            @(posedge clk); #1; k++;
            if (k == 1) begin n1 = psram_nce; o1 = psram_oe; end
            if (k == 10) do_write = 1'b0;
            if (!busy) break;
        end
        tests++;
        if (n1 !== 1'b0 || o1 !== 1'b1) begin
            fails++; $display("FAIL init_start: nce=%b oe=%b one clk after release, need 0 1", n1, o1);
        end
        tests++;
        if (k != 19) begin
            fails++; $display("FAIL init_busy_release: busy fell after %0d clk, need 19", k);
        end
        tests++;
        if (frames - f0 != 1 || last_len != 8 || valid_cnt != v0) begin
            fails++; $display("FAIL init_frame: frames=%0d len=%0d valids=%0d, need 1 8 0",
                              frames - f0, last_len, valid_cnt - v0);
        end
        b = 8'h35; bad = -1;
        for (int i = 0; i < 8; i++)
            if ((last_nib[i] !== {3'b000, b[7-i]} || last_oe[i] !== 1'b1) && bad < 0) bad = i;
        tests++;
        if (bad >= 0) begin
            fails++; $display("FAIL init_bits: period %0d sout=%h oe=%b, need %h 1",
                              bad, last_nib[bad], last_oe[bad], {3'b000, b[7-bad]});
        end
    endtask

    task automatic test_write(input logic [23:0] a, input logic [31:0] d);
        int vc, ic, f0, bad; logic [31:0] rv; logic n1, b1; logic [63:0] fr;
        f0 = frames;
        do_xfer(1'b0, 1'b1, a, d, vc, ic, rv, n1, b1);
        exp_mem[a] = d;
        fr = {8'h38, a, d};
        tests++;
        if (n1 !== 1'b0 || b1 !== 1'b1) begin
            fails++; $display("FAIL write_start: nce=%b busy=%b at N+1, need 0 1", n1, b1);
        end
        tests++;
        if (vc != 33 || ic != 35) begin
            fails++; $display("FAIL write_timing: valid at N+%0d idle at N+%0d, need 33 35", vc, ic);
        end
        tests++;
        if (frames - f0 != 1 || last_len != 16) begin
            fails++; $display("FAIL write_frame: frames=%0d len=%0d, need 1 16", frames - f0, last_len);
        end
        bad = -1;
        for (int i = 0; i < 16; i++)
            if ((last_nib[i] !== fr[63-4*i -: 4] || last_oe[i] !== 1'b1) && bad < 0) bad = i;
        tests++;
        if (bad >= 0) begin
            fails++; $display("FAIL write_nibbles: addr=%h nibble %0d=%h oe=%b, need %h 1",
                              a, bad, last_nib[bad], last_oe[bad], fr[63-4*bad -: 4]);
        end
    endtask

    task automatic test_read(input logic [23:0] a);
        int vc, ic, f0, bad; logic [31:0] rv, ex; logic n1, b1; logic [31:0] hdr;
        ex = exp_read(a);
        f0 = frames;
        do_xfer(1'b1, 1'b0, a, 32'h0, vc, ic, rv, n1, b1);
        hdr = {8'hEB, a};
        tests++;
        if (vc != 45 || ic != 47) begin
            fails++; $display("FAIL read_timing: valid at N+%0d idle at N+%0d, need 45 47", vc, ic);
        end
        tests++;
        if (rv !== ex) begin
            fails++; $display("FAIL read_data: addr=%h rdata=%h, need %h", a, rv, ex);
        end
        tests++;
        if (frames - f0 != 1 || last_len != 16 + RW) begin
            fails++; $display("FAIL read_frame: frames=%0d len=%0d, need 1 %0d", frames - f0, last_len, 16 + RW);
        end
        bad = -1;
        for (int i = 0; i < 16 + RW; i++) begin
            if (i < 8 && last_nib[i] !== hdr[31-4*i -: 4] && bad < 0) bad = i;
            if (last_oe[i] !== (i < 8) && bad < 0) bad = i;
        end
        tests++;
        if (bad >= 0) begin
            fails++; $display("FAIL read_header_oe: addr=%h period %0d sout=%h oe=%b", a, bad, last_nib[bad], last_oe[bad]);
        end
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (rdata !== ex) begin
            fails++; $display("FAIL read_hold: rdata=%h after idle, need %h", rdata, ex);
        end
    endtask

    task automatic test_both(input logic [23:0] a, input logic [31:0] d);
        int vc, ic, f0, v0; logic [31:0] rv, ex; logic n1, b1; logic had; logic [31:0] old;
        ex = exp_read(a);
        had = psram_mem.exists(a);
        old = had ? psram_mem[a] : 32'h0;
        f0 = frames; v0 = valid_cnt;
        do_xfer(1'b1, 1'b1, a, d, vc, ic, rv, n1, b1);
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if ({last_nib[0], last_nib[1]} !== 8'hEB || frames - f0 != 1 || valid_cnt - v0 != 1) begin
            fails++; $display("FAIL both_read_wins: cmd=%h%h frames=%0d valids=%0d, need EB 1 1",
                              last_nib[0], last_nib[1], frames - f0, valid_cnt - v0);
        end
        tests++;
        if (rv !== ex || psram_mem.exists(a) !== had || (had && psram_mem[a] !== old)) begin
            fails++; $display("FAIL both_data: rdata=%h need %h, write must be dropped", rv, ex);
        end
    endtask

    task automatic test_busy_ignore(input logic [23:0] a, input logic [23:0] wa);
        int k, f0, v0; logic [31:0] ex;
        ex = exp_read(a);
        f0 = frames; v0 = valid_cnt;
        addr = a; do_read = 1'b1;
        @(posedge clk); #1;
        do_read = 1'b0;
        k = 1;
        while (busy && k < 200) begin
            if (k == 20) begin addr = wa; wdata = 32'h1234_5678; do_write = 1'b1; end
            if (k == 21) do_write = 1'b0;
            @(posedge clk); #1; k++;
        end
        do_write = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        tests++;
        if (frames - f0 != 1 || valid_cnt - v0 != 1) begin
            fails++; $display("FAIL busy_ignore: frames=%0d valids=%0d, need 1 1", frames - f0, valid_cnt - v0);
        end
        tests++;
        if (rdata !== ex || psram_mem.exists(wa)) begin
            fails++; $display("FAIL busy_ignore_data: rdata=%h need %h, stray write=%b", rdata, ex, psram_mem.exists(wa));
        end
    endtask

    task automatic test_back_to_back();
        int vc1, ic1, vc2, ic2, vc3, ic3; logic [31:0] rv; logic n1, b1;
        logic [23:0] a1, a2; logic [31:0] d1, d2;
        a1 = 24'($urandom); a2 = a1 ^ 24'h000400; d1 = $urandom; d2 = $urandom;
        do_xfer(1'b0, 1'b1, a1, d1, vc1, ic1, rv, n1, b1);
        exp_mem[a1] = d1;
        do_xfer(1'b0, 1'b1, a2, d2, vc2, ic2, rv, n1, b1);
        exp_mem[a2] = d2;
        do_xfer(1'b1, 1'b0, a1, 32'h0, vc3, ic3, rv, n1, b1);
        tests++;
        if (vc2 != 33 || ic2 != 35 || vc3 != 45 || ic3 != 47) begin
            fails++; $display("FAIL back_to_back_timing: valid %0d/%0d idle %0d/%0d, need 33/45 35/47", vc2, vc3, ic2, ic3);
        end
        tests++;
        if (rv !== d1 || psram_mem[a2] !== d2) begin
            fails++; $display("FAIL back_to_back_data: rdata=%h need %h, mem[a2]=%h need %h", rv, d1, psram_mem[a2], d2);
        end
    endtask

    task automatic test_reset_mid_write(input logic [23:0] a, input logic [31:0] d, input logic [23:0] ok_addr);
        int k, v0, g;
        g = 0;
        while (busy && g < 200) begin @(posedge clk); #1; g++; end
        addr = a; wdata = d; do_write = 1'b1;
        @(posedge clk); #1;
        do_write = 1'b0;
        repeat (7) @(posedge clk);
        #1;  // cycle N+8: inside the address phase
        v0 = valid_cnt;
        rst = 1'b1;
        #1;
        tests++;
        if (psram_nce !== 1'b1 || psram_sclk !== 1'b0 || psram_oe !== 1'b0 || valid !== 1'b0
            || busy !== 1'b1 || rdata !== 32'h0) begin
            fails++; $display("FAIL abort_values: nce=%b sclk=%b oe=%b valid=%b busy=%b rdata=%h",
                              psram_nce, psram_sclk, psram_oe, valid, busy, rdata);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        while (k < 100) begin
            @(posedge clk); #1; k++;
            if (!busy) break;
        end
        tests++;
        if (k != 19 || valid_cnt != v0 || last_len != 8) begin
            fails++; $display("FAIL abort_reinit: idle after %0d clk valids=%0d init len=%0d, need 19 0 8",
                              k, valid_cnt - v0, last_len);
        end
        test_read(ok_addr);
        test_read(a);
    endtask

    task automatic test_protocol();
        tests++;
        if (proto_err != 0) begin
            fails++; $display("FAIL sclk_while_deselected: %0d clk with nce=1 and sclk=1, need 0", proto_err);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] wq [$];
        logic [23:0] ra;
        logic [31:0] rd;
        test_reset();
        test_write(24'h123456, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            ra = 24'($urandom);
            rd = $urandom;
            test_write(ra, rd);
            wq.push_back(ra);
        end
        psram_mem[24'h000010] = 32'hCAFEF00D;
        exp_mem[24'h000010]   = 32'hCAFEF00D;
        test_read(24'h000010);
        test_read(24'h123456);
        foreach (wq[i]) test_read(wq[i]);
        test_read(24'($urandom));
        test_both(wq[0], 32'hA5A5_5A5A);
        test_busy_ignore(24'h123456, 24'hFEDCB0);
        test_back_to_back();
        test_reset_mid_write(24'hABCDE0, 32'h0BAD_F00D, 24'h123456);
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
